axi_rd_responder: RTL and testbench
===================================

AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

Interface
REQ-001 Parameters SHALL be:
- ADDR_WIDTH, default 33: AR address width.
- DATA_WIDTH, default 256: R data width, 256 or 512.
- ID_WIDTH, default 5: ARID/RID width.
- AR_DEPTH, default 16: AR queue entries, power of two.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 cfg_latency  in  16  extra wait cycles before each burst's first beat; sampled at dequeue.
REQ-005 stat_clear  in  1  one-cycle pulse; zeroes both statistics counters.
REQ-006 s_axi_ARVALID, s_axi_ARREADY  in, out  1 each  AR handshake.
REQ-007 s_axi_ARADDR  in  ADDR_WIDTH  byte address.
REQ-008 s_axi_ARID, s_axi_ARLEN  in  ID_WIDTH, 8  ID and burst length (beats = ARLEN+1).
REQ-009 s_axi_ARSIZE, s_axi_ARBURST  in  3, 2  size (ignored) and burst type.
REQ-010 s_axi_ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION  in  2/4/3/4/4  ignored.
REQ-011 s_axi_RVALID, s_axi_RREADY  out, in  1 each  R handshake.
REQ-012 s_axi_RDATA  out  DATA_WIDTH  pattern data.
REQ-013 s_axi_RID, s_axi_RRESP, s_axi_RLAST  out  ID_WIDTH, 2, 1  response ID, status, last beat.
REQ-014 stat_ar_cnt, stat_rlast_cnt  out  32 each  accepted ARs, completed bursts; wrap modulo 2^32.

Function
REQ-015 AR handshake SHALL be ARVALID&ARREADY; each accepted request pushes {ARADDR, ARID, ARLEN, ARBURST} into an AR_DEPTH-entry FIFO.
REQ-016 ARREADY SHALL equal (FIFO not full); no bypass: when full, ARREADY stays low even in a pop cycle.
REQ-017 FSM states: R_IDLE, R_WAIT, R_BURST.
REQ-018 R_IDLE, FIFO non-empty: pop head into burst registers, load wait counter with cfg_latency, go R_WAIT.
REQ-019 R_IDLE, FIFO empty: stay in R_IDLE.
REQ-020 R_WAIT: counter==0 -> R_BURST with RVALID=1 registered; otherwise decrement the counter.
REQ-021 Latency: AR accepted in cycle N into an empty FIFO with FSM in R_IDLE -> first RVALID in cycle N+3+cfg_latency.
REQ-022 R_BURST: RVALID held high; RDATA/RID/RRESP/RLAST held stable while RREADY=0.
REQ-023 Each RVALID&RREADY advances the beat index.
REQ-024 RLAST=1 only on beat ARLEN; after its handshake RVALID drops and the FSM returns to R_IDLE.
REQ-025 After a last beat accepted in cycle M, the next burst's first RVALID is no earlier than M+3+cfg_latency.
REQ-026 Beat address = ARADDR + beat_index*(DATA_WIDTH/8), computed in ADDR_WIDTH bits with wrap-around.
REQ-027 RDATA = beat address zero-extended to 64 bits, replicated DATA_WIDTH/64 times.
REQ-028 RID = the burst's ARID.
REQ-029 RRESP = 2'b00 if ARBURST==2'b01 (INC); otherwise 2'b10 (SLVERR) on every beat, with data and beat count unchanged.
REQ-030 ARLEN=0 -> single beat with RLAST=1.
REQ-031 ARLEN=255 -> 256 beats; beat index is 8 bits, no overflow.
REQ-032 stat_ar_cnt increments once per AR handshake.
REQ-033 stat_rlast_cnt increments once per RLAST handshake.
REQ-034 stat_clear in the same cycle as an increment: the counter becomes 0 (clear wins).
REQ-035 Simultaneous push and pop with FIFO neither full nor empty: occupancy unchanged, order preserved.
REQ-036 Bursts SHALL be returned strictly in AR acceptance order, one burst at a time, with no interleaving.

Reset
REQ-037 With rst_n=0 at a clock edge, next cycle SHALL show: FIFO empty, FSM R_IDLE, wait counter 0, beat index 0.
REQ-038 Output values after that reset edge: RVALID=0, RLAST=0, RRESP=0, RID=0, RDATA=0, ARREADY=1 (from cycle after reset deasserts), both stats 0.
REQ-039 Reset mid-burst or mid-wait SHALL discard all queued and in-flight requests with no further R beats.

Verification
REQ-040 cfg_latency=0, one AR (ADDR=0x1000, ID=3, LEN=3, INC) in cycle N -> RVALID cycles N+3..N+6; RDATA 64-bit lanes 0x1000/0x1020/0x1040/0x1060 (DATA_WIDTH=256); RID=3; RLAST on 4th beat only; RRESP=0.
REQ-041 cfg_latency=10, ARLEN=0 -> single beat in cycle N+13 with RLAST=1; stat_rlast_cnt=1 afterwards.
REQ-042 RREADY held low for 5 cycles mid-burst -> outputs frozen; total beat count still ARLEN+1.
REQ-043 RREADY=0, issue 17 ARs back-to-back -> ARREADY low once 16 entries are queued, refills after pops; responses returned in ID order; stat_ar_cnt=17.
REQ-044 ARBURST=2'b00, ARLEN=1 -> 2 beats, both RRESP=2'b10.
REQ-045 Reset asserted on 2nd beat of an ARLEN=7 burst with 3 ARs queued -> RVALID=0 the next cycle, no beats after release; stat counters 0.

Source files
------------

// File: rtl/axi_rd_responder_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// axi_rd_responder_if : AXI4 read-channel (AR + R) bundle with master/slave views
// Rev 1.0
// -----------------------------------------------------------------------------
interface axi_rd_responder_if #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 5
);
  logic                  ARVALID;
  logic                  ARREADY;
  logic [ADDR_WIDTH-1:0] ARADDR;
  logic [ID_WIDTH-1:0]   ARID;
  logic [7:0]            ARLEN;
  logic [2:0]            ARSIZE;
  logic [1:0]            ARBURST;
  logic [1:0]            ARLOCK;
  logic [3:0]            ARCACHE;
  logic [2:0]            ARPROT;
  logic [3:0]            ARQOS;
  logic [3:0]            ARREGION;

  logic                  RVALID;
  logic                  RREADY;
  logic [DATA_WIDTH-1:0] RDATA;
  logic [ID_WIDTH-1:0]   RID;
  logic [1:0]            RRESP;
  logic                  RLAST;

  modport master (
    output ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST,
           ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, RREADY,
    input  ARREADY, RVALID, RDATA, RID, RRESP, RLAST
  );

  modport slave (
    input  ARVALID, ARADDR, ARID, ARLEN, ARSIZE, ARBURST,
           ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION, RREADY,
    output ARREADY, RVALID, RDATA, RID, RRESP, RLAST
  );
endinterface
`default_nettype wire

// File: rtl/axi_rd_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// axi_rd_responder : queued AXI4 read responder returning address-pattern data
// Rev 1.0
// -----------------------------------------------------------------------------
module axi_rd_responder #(
  parameter int ADDR_WIDTH = 33,
  parameter int DATA_WIDTH = 256,
  parameter int ID_WIDTH   = 5,
  parameter int AR_DEPTH   = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  input  wire logic [15:0] cfg_latency,
  input  wire logic        stat_clear,
  output logic [31:0]      stat_ar_cnt,
  output logic [31:0]      stat_rlast_cnt,
  axi_rd_responder_if.slave s_axi
);

  localparam int PTR_W      = $clog2(AR_DEPTH);
  localparam int ENT_W      = ADDR_WIDTH + ID_WIDTH + 8 + 2;
  localparam int LANES      = DATA_WIDTH / 64;
  localparam int BEAT_SHIFT = $clog2(DATA_WIDTH / 8);

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_WAIT  = 2'd1,
    R_BURST = 2'd2
  } state_e;

  // AR request FIFO; pointers carry one extra wrap bit
  logic [ENT_W-1:0] fifo_mem_q [AR_DEPTH];
  logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
  logic             w_full, w_empty, w_push, w_pop;
  logic [ENT_W-1:0] w_head;

  state_e                state_q, state_d;
  logic [15:0]           wait_q, wait_d;
  logic [7:0]            beat_q, beat_d;
  logic [7:0]            len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;
  logic [1:0]            burst_q, burst_d;

  logic                  w_rvalid, w_rlast, w_r_hs, w_last_hs;
  logic [ADDR_WIDTH-1:0] w_beat_addr;
  logic                  w_unused_ok;

  assign w_full  = (wr_ptr_q - rd_ptr_q) == (PTR_W+1)'(AR_DEPTH);
  assign w_empty = (wr_ptr_q == rd_ptr_q);
  assign w_push  = s_axi.ARVALID && !w_full;
  assign w_head  = fifo_mem_q[rd_ptr_q[PTR_W-1:0]];

  assign s_axi.ARREADY = !w_full;

  assign w_unused_ok = ^{s_axi.ARSIZE, s_axi.ARLOCK, s_axi.ARCACHE,
                         s_axi.ARPROT, s_axi.ARQOS, s_axi.ARREGION};

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_mem_q[wr_ptr_q[PTR_W-1:0]] <= {s_axi.ARADDR, s_axi.ARID, s_axi.ARLEN, s_axi.ARBURST};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (w_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    beat_d  = beat_q;
    len_d   = len_q;
    addr_d  = addr_q;
    id_d    = id_q;
    burst_d = burst_q;
    w_pop   = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (!w_empty) begin
          w_pop   = 1'b1;
          {addr_d, id_d, len_d, burst_d} = w_head;
          wait_d  = cfg_latency;
          beat_d  = 8'd0;
          state_d = R_WAIT;
        end
      end
      R_WAIT: begin
        if (wait_q == 16'd0) state_d = R_BURST;
        else                 wait_d  = wait_q - 16'd1;
      end
      R_BURST: begin
        if (s_axi.RREADY) begin
          if (beat_q == len_q) begin
            beat_d  = 8'd0;
            state_d = R_IDLE;
          end else begin
            beat_d  = beat_q + 8'd1;
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= R_IDLE;
      wait_q  <= '0;
      beat_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      id_q    <= '0;
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      beat_q  <= beat_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      id_q    <= id_d;
      burst_q <= burst_d;
    end
  end

  // Beat address wraps naturally within ADDR_WIDTH bits
  assign w_beat_addr = addr_q + (ADDR_WIDTH'(beat_q) << BEAT_SHIFT);
  assign w_rvalid    = (state_q == R_BURST);
  assign w_rlast     = w_rvalid && (beat_q == len_q);
  assign w_r_hs      = w_rvalid && s_axi.RREADY;
  assign w_last_hs   = w_r_hs && w_rlast;

  assign s_axi.RVALID = w_rvalid;
  assign s_axi.RLAST  = w_rlast;
  assign s_axi.RID    = id_q;
  assign s_axi.RRESP  = (w_rvalid && (burst_q != 2'b01)) ? 2'b10 : 2'b00;
  assign s_axi.RDATA  = {LANES{64'(w_beat_addr)}};

  // Clear has priority over a coincident increment
  always_ff @(posedge clk) begin
    if (!rst_n || stat_clear) begin
      stat_ar_cnt    <= '0;
      stat_rlast_cnt <= '0;
    end else begin
      if (w_push)    stat_ar_cnt    <= stat_ar_cnt + 32'd1;
      if (w_last_hs) stat_rlast_cnt <= stat_rlast_cnt + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_rd_responder.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_axi_rd_responder : vector table plus scoreboard bench for axi_rd_responder
// Rev 1.0
// -----------------------------------------------------------------------------
module tb_axi_rd_responder;
  localparam int AW    = 33;
  localparam int DW    = 256;
  localparam int IDW   = 5;
  localparam int LANES = DW / 64;
  localparam int BOUND = 3000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] cfg_latency = 16'd0;
  logic        stat_clear = 1'b0;
  logic [31:0] stat_ar_cnt, stat_rlast_cnt;

  axi_rd_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW)) s_axi ();

  axi_rd_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .AR_DEPTH(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .cfg_latency    (cfg_latency),
    .stat_clear     (stat_clear),
    .stat_ar_cnt    (stat_ar_cnt),
    .stat_rlast_cnt (stat_rlast_cnt),
    .s_axi          (s_axi)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0]  data;
    logic [IDW-1:0] id;
    logic [1:0]     resp;
    logic           last;
  } beat_t;

  typedef struct {
    logic [15:0]    lat;
    logic [AW-1:0]  addr;
    logic [IDW-1:0] id;
    logic [7:0]     len;
    logic [1:0]     bt;
    int             exp_lat;
    int             exp_beats;
    logic [1:0]     exp_resp;
  } vec_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    beats = 0;

  function automatic void push_burst(input logic [AW-1:0] a, input logic [IDW-1:0] id,
                                     input logic [7:0] len, input logic [1:0] bt);
    beat_t         b;
    logic [AW-1:0] ba;
    for (int i = 0; i <= int'(len); i++) begin
      ba = a + AW'(i * (DW / 8));
      for (int k = 0; k < LANES; k++) b.data[k*64 +: 64] = 64'(ba);
      b.id   = id;
      b.resp = (bt == 2'b01) ? 2'b00 : 2'b10;
      b.last = (i == int'(len));
      exp_q.push_back(b);
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Scoreboard: push on AR handshake, pop/compare on R handshake, hold check on stall
  initial begin
    beat_t cur, e, held;
    logic  stall;
    stall = 1'b0;
    held  = '0;
    forever begin
      @(negedge clk);
      cur = {s_axi.RDATA, s_axi.RID, s_axi.RRESP, s_axi.RLAST};
      if (rst_n) begin
        if (s_axi.ARVALID && s_axi.ARREADY)
          push_burst(s_axi.ARADDR, s_axi.ARID, s_axi.ARLEN, s_axi.ARBURST);
        if (stall && s_axi.RVALID) begin
          n_cmp++;
          if (cur !== held) begin
            n_fail++;
            $display("FAIL stall_hold: got %h required %h", cur, held);
          end
        end
        if (s_axi.RVALID && s_axi.RREADY) begin
          n_cmp++;
          beats++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_beat: got id=%0d last=%0b required no beat", cur.id, cur.last);
          end else begin
            e = exp_q.pop_front();
            if (cur !== e) begin
              n_fail++;
              $display("FAIL beat: got id=%0d resp=%0d last=%0b lane0=%h required id=%0d resp=%0d last=%0b lane0=%h",
                       cur.id, cur.resp, cur.last, cur.data[63:0], e.id, e.resp, e.last, e.data[63:0]);
            end
          end
        end
      end
      stall = rst_n && s_axi.RVALID && !s_axi.RREADY;
      held  = cur;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, req);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got timeout required event", nm);
  endtask

  // Called and returns at posedge+1; holds ARVALID until the handshake edge
  task automatic send_ar(input logic [AW-1:0] a, input logic [IDW-1:0] id,
                         input logic [7:0] len, input logic [1:0] bt, output int acc);
    s_axi.ARVALID  = 1'b1;
    s_axi.ARADDR   = a;
    s_axi.ARID     = id;
    s_axi.ARLEN    = len;
    s_axi.ARBURST  = bt;
    s_axi.ARSIZE   = 3'($urandom);
    s_axi.ARCACHE  = 4'($urandom);
    s_axi.ARQOS    = 4'($urandom);
    acc = -1;
    for (int t = 0; t < BOUND && acc < 0; t++) begin
      if (s_axi.ARREADY) acc = cyc;
      tick();
    end
    s_axi.ARVALID = 1'b0;
    if (acc < 0) timeout_fail("ar_accept");
  endtask

  task automatic wait_rvalid(output int first);
    first = -1;
    for (int t = 0; t < BOUND && first < 0; t++) begin
      if (s_axi.RVALID) first = cyc;
      else tick();
    end
    if (first < 0) timeout_fail("rvalid_wait");
  endtask

  task automatic drain();
    int done;
    done = 0;
    for (int t = 0; t < BOUND && done == 0; t++) begin
      if (exp_q.size() == 0 && !s_axi.RVALID) done = 1;
      else tick();
    end
    if (done == 0) timeout_fail("drain");
  endtask

  initial begin
    vec_t vt[7];
    int   acc, first, b0, m_ar, m_rl, ok;

    vt[0] = '{16'd0,  33'h0_0000_1000, 5'd3,  8'd3,   2'b01, 3,  4,   2'b00};
    vt[1] = '{16'd10, 33'h0_0000_2000, 5'd7,  8'd0,   2'b01, 13, 1,   2'b00};
    vt[2] = '{16'd2,  33'h0_0000_0300, 5'd1,  8'd1,   2'b00, 5,  2,   2'b10};
    vt[3] = '{16'd1,  33'h1_FFFF_FFE0, 5'd2,  8'd2,   2'b01, 4,  3,   2'b00};
    vt[4] = '{16'd0,  33'h0_0000_0040, 5'd4,  8'd255, 2'b01, 3,  256, 2'b00};
    vt[5] = '{16'd5,  33'h0_0000_0123, 5'd9,  8'd2,   2'b10, 8,  3,   2'b10};
    vt[6] = '{16'd0,  33'h0_0000_07F0, 5'd31, 8'd1,   2'b11, 3,  2,   2'b10};

    s_axi.ARVALID = 1'b0; s_axi.ARADDR = '0; s_axi.ARID = '0; s_axi.ARLEN = '0;
    s_axi.ARSIZE = '0; s_axi.ARBURST = '0; s_axi.ARLOCK = '0; s_axi.ARCACHE = '0;
    s_axi.ARPROT = '0; s_axi.ARQOS = '0; s_axi.ARREGION = '0; s_axi.RREADY = 1'b1;

    rst_n = 1'b0;
    tick(); tick();
    chk("rst_rvalid", 64'(s_axi.RVALID), 0);
    chk("rst_rlast", 64'(s_axi.RLAST), 0);
    chk("rst_rresp", 64'(s_axi.RRESP), 0);
    chk("rst_rid", 64'(s_axi.RID), 0);
    chk("rst_rdata_any", 64'(|s_axi.RDATA), 0);
    chk("rst_stat_ar", 64'(stat_ar_cnt), 0);
    chk("rst_stat_rlast", 64'(stat_rlast_cnt), 0);
    rst_n = 1'b1;
    tick();
    chk("rst_arready", 64'(s_axi.ARREADY), 1);

    m_ar = 0;
    m_rl = 0;
    for (int i = 0; i < 7; i++) begin
      cfg_latency = vt[i].lat;
      b0 = beats;
      send_ar(vt[i].addr, vt[i].id, vt[i].len, vt[i].bt, acc);
      wait_rvalid(first);
      chk($sformatf("v%0d_latency", i), 64'(first - acc), 64'(vt[i].exp_lat));
      chk($sformatf("v%0d_resp", i), 64'(s_axi.RRESP), 64'(vt[i].exp_resp));
      drain();
      m_ar++;
      m_rl++;
      chk($sformatf("v%0d_beats", i), 64'(beats - b0), 64'(vt[i].exp_beats));
      chk($sformatf("v%0d_stat_ar", i), 64'(stat_ar_cnt), 64'(m_ar));
      chk($sformatf("v%0d_stat_rlast", i), 64'(stat_rlast_cnt), 64'(m_rl));
    end

    // RREADY low for 5 cycles mid-burst
    cfg_latency = 16'd0;
    b0 = beats;
    send_ar(33'h5000, 5'd5, 8'd7, 2'b01, acc);
    ok = 0;
    for (int t = 0; t < BOUND && ok == 0; t++) begin
      if (beats - b0 >= 2) ok = 1;
      else tick();
    end
    if (ok == 0) timeout_fail("stall_setup");
    s_axi.RREADY = 1'b0;
    repeat (5) tick();
    chk("stall_rvalid_held", 64'(s_axi.RVALID), 1);
    s_axi.RREADY = 1'b1;
    drain();
    chk("stall_beats", 64'(beats - b0), 8);

    // Clear pulse, then clear coinciding with an AR handshake
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    chk("clear_ar", 64'(stat_ar_cnt), 0);
    chk("clear_rlast", 64'(stat_rlast_cnt), 0);
    stat_clear = 1'b1;
    send_ar(33'h6000, 5'd6, 8'd0, 2'b01, acc);
    stat_clear = 1'b0;
    chk("clear_wins_ar", 64'(stat_ar_cnt), 0);
    drain();
    chk("after_clear_rlast", 64'(stat_rlast_cnt), 1);

    // 17 back-to-back ARs with RREADY low: FIFO fills, then refills after pops
    stat_clear = 1'b1;
    tick();
    stat_clear = 1'b0;
    s_axi.RREADY = 1'b0;
    for (int i = 0; i < 17; i++)
      send_ar(AW'(32'h10000 + i * 32'h100), IDW'(i), 8'd1, 2'b01, acc);
    chk("full_arready", 64'(s_axi.ARREADY), 0);
    chk("full_stat_ar", 64'(stat_ar_cnt), 17);
    s_axi.RREADY = 1'b1;
    ok = 0;
    for (int t = 0; t < BOUND && ok == 0; t++) begin
      if (s_axi.ARREADY) ok = 1;
      else tick();
    end
    chk("refill_arready", 64'(s_axi.ARREADY), 1);
    drain();
    chk("full_stat_rlast", 64'(stat_rlast_cnt), 17);

    // Reset on the 2nd beat of an ARLEN=7 burst with 3 more queued
    s_axi.RREADY = 1'b0;
    for (int i = 0; i < 4; i++)
      send_ar(AW'(32'h20000 + i * 32'h1000), IDW'(20 + i), 8'd7, 2'b01, acc);
    s_axi.RREADY = 1'b1;
    b0 = beats;
    ok = 0;
    for (int t = 0; t < BOUND && ok == 0; t++) begin
      if (beats - b0 >= 1) ok = 1;
      else tick();
    end
    if (ok == 0) timeout_fail("rst_setup");
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    chk("midrst_rvalid", 64'(s_axi.RVALID), 0);
    chk("midrst_stat_ar", 64'(stat_ar_cnt), 0);
    chk("midrst_stat_rlast", 64'(stat_rlast_cnt), 0);
    rst_n = 1'b1;
    b0 = beats;
    repeat (60) tick();
    chk("midrst_no_beats", 64'(beats - b0), 0);
    chk("midrst_arready", 64'(s_axi.ARREADY), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
